// File: rtl/score_ctrl.sv
// score_ctrl: game-flow FSM with BCD score, high score and frame-synchronous display latch
module score_ctrl #(
    parameter int BLINK_FRAMES = 30,
    parameter int OVER_FRAMES  = 180
) (
    input  logic        clk75MHz,
    input  logic        rst_n,
    input  logic        start,
    input  logic        point,
    input  logic        Kollision,
    input  logic        frame_start,
    output logic [15:0] Punkte,
    output logic [15:0] HighScore,
    output logic [1:0]  state,
    output logic        game_active,
    output logic        show_digits
);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [15:0]   score_q, score_d, punkte_q, punkte_d, high_q, high_d;
    logic [7:0]    frame_q, frame_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          show_q, show_d;
    logic [15:0]   score_nx;

    // BCD +1 with per-nibble carry; 9999 saturates
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return (v == 16'h9999) ? v : r;
    endfunction

    // next-state, score, high score, blink/frame counters and display latch
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        high_d   = high_q;
        frame_d  = frame_q;
        blink_d  = blink_q;
        show_d   = show_q;
        punkte_d = frame_start ? score_q : punkte_q;
        score_nx = point ? bcd_inc(score_q) : score_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    score_d = 16'h0000;
                end
            end
            RUN: begin
                score_d = score_nx;
                if (Kollision) begin
                    state_d = OVER;
                    high_d  = (score_nx > high_q) ? score_nx : high_q;
                    frame_d = 8'd0;
                    blink_d = '0;
                end
            end
            OVER: begin
                if (frame_start) begin
                    frame_d = frame_q + 8'd1;
                    blink_d = (blink_q + BW'(1) == BW'(BLINK_FRAMES)) ? '0 : blink_q + BW'(1);
                    show_d  = (blink_q + BW'(1) == BW'(BLINK_FRAMES)) ? ~show_q : show_q;
                    if (frame_q + 8'd1 == 8'(OVER_FRAMES)) begin
                        state_d = IDLE;
                        show_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with asynchronous reset
    always_ff @(posedge clk75MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            score_q  <= 16'h0000;
            punkte_q <= 16'h0000;
            high_q   <= 16'h0000;
            frame_q  <= 8'd0;
            blink_q  <= '0;
            show_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            punkte_q <= punkte_d;
            high_q   <= high_d;
            frame_q  <= frame_d;
            blink_q  <= blink_d;
            show_q   <= show_d;
        end
    end

    assign Punkte      = punkte_q;
    assign HighScore   = high_q;
    assign state       = state_q;
    assign game_active = (state_q == RUN);
    assign show_digits = show_q;
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: randomized and directed checks of score_ctrl against a decimal-integer game model
module tb_score_ctrl;
    localparam int BLINK = 2;
    localparam int OVERF = 6;

    logic        clk75MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, point = 1'b0, Kollision = 1'b0, frame_start = 1'b0;
    logic [15:0] Punkte, HighScore;
    logic [1:0]  state;
    logic        game_active, show_digits;

    int n_chk = 0, n_pass = 0;
    int m_state, m_score, m_high, m_punkte, m_fc, m_bc;
    bit m_show;

    score_ctrl #(.BLINK_FRAMES(BLINK), .OVER_FRAMES(OVERF)) dut (
        .clk75MHz(clk75MHz), .rst_n(rst_n), .start(start), .point(point),
        .Kollision(Kollision), .frame_start(frame_start), .Punkte(Punkte),
        .HighScore(HighScore), .state(state), .game_active(game_active),
        .show_digits(show_digits)
    );

    always #5 clk75MHz = ~clk75MHz;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic compare_all();
        check("Punkte", Punkte, to_bcd(m_punkte));
        check("HighScore", HighScore, to_bcd(m_high));
        check("state", 16'(state), 16'(m_state));
        check("game_active", 16'(game_active), 16'(m_state == 1));
        check("show_digits", 16'(show_digits), 16'(m_show));
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_punkte = 0; m_fc = 0; m_bc = 0; m_show = 1;
    endtask

    task automatic model_step(input bit s, input bit p, input bit k, input bit f);
        if (f) m_punkte = m_score;
        if (m_state == 0) begin
            if (s) begin m_state = 1; m_score = 0; end
        end else if (m_state == 1) begin
            if (p && m_score < 9999) m_score++;
            if (k) begin
                m_state = 2;
                if (m_score > m_high) m_high = m_score;
                m_fc = 0; m_bc = 0;
            end
        end else if (f) begin
            m_fc++; m_bc++;
            if (m_bc == BLINK) begin m_bc = 0; m_show = !m_show; end
            if (m_fc == OVERF) begin m_state = 0; m_show = 1; end
        end
    endtask

    task automatic step(input bit s, input bit p, input bit k, input bit f);
        start = s; point = p; Kollision = k; frame_start = f;
        @(posedge clk75MHz);
        model_step(s, p, k, f);
        #1;
        compare_all();
        start = 0; point = 0; Kollision = 0; frame_start = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        start = 0; point = 0; Kollision = 0; frame_start = 0;
        model_reset();
        @(posedge clk75MHz);
        #1;
        compare_all();
        rst_n = 1;
    endtask

    task automatic points(input int n);
        repeat (n) step(0, 1, 0, 0);
    endtask

    task automatic wait_over();
        repeat (OVERF) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
    endtask

    initial begin
        do_reset();
        points(5);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        check("idle_punkte", Punkte, 16'h0000);
        check("idle_state", 16'(state), 16'd0);

        do_reset();
        step(1, 0, 0, 0);
        points(10);
        step(0, 0, 0, 1);
        check("carry_10", Punkte, 16'h0010);
        points(90);
        step(0, 0, 0, 1);
        check("carry_100", Punkte, 16'h0100);

        do_reset();
        step(1, 0, 0, 0);
        points(42);
        step(0, 0, 1, 0);
        check("hs_game1", HighScore, 16'h0042);
        step(0, 0, 0, 1);
        check("blink_f1", 16'(show_digits), 16'd1);
        step(0, 0, 0, 1);
        check("blink_f2", 16'(show_digits), 16'd0);
        step(1, 0, 0, 1);
        check("over_start_ign", 16'(state), 16'd2);
        step(0, 0, 0, 1);
        check("blink_f4", 16'(show_digits), 16'd1);
        step(0, 0, 0, 1);
        check("over_f5", 16'(state), 16'd2);
        step(0, 0, 0, 1);
        check("over_exit", 16'(state), 16'd0);
        check("over_exit_show", 16'(show_digits), 16'd1);
        step(1, 0, 0, 0);
        points(16);
        step(0, 1, 1, 0);
        check("hs_game2", HighScore, 16'h0042);
        wait_over();
        step(1, 0, 0, 0);
        points(42);
        step(0, 1, 1, 0);
        check("hs_game3", HighScore, 16'h0043);
        wait_over();

        do_reset();
        step(1, 0, 0, 0);
        points(10002);
        step(0, 0, 0, 1);
        check("saturate", Punkte, 16'h9999);

        do_reset();
        step(1, 0, 0, 0);
        points(123);
        step(0, 0, 0, 1);
        check("pre_rst_punkte", Punkte, 16'h0123);
        @(posedge clk75MHz);
        #3 rst_n = 0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk75MHz);
        #1 rst_n = 1;
        step(1, 0, 0, 0);
        check("post_rst_run", 16'(state), 16'd1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(19) == 0, $urandom_range(2) == 0,
                 $urandom_range(39) == 0, $urandom_range(7) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/score_ctrl.md
# score_ctrl

Game-flow and score controller that sequences the on-screen score digits. It counts points as a 4-digit BCD score, tracks the high score, and runs the IDLE/RUN/OVER game state machine. It hands the digit renderer frame-synchronous `Punkte` and `HighScore` words so the digits never change mid-frame. It sits between the game logic (point and collision pulses, start button) and the digit display block, in the 75 MHz pixel clock domain.

## Interface
Parameters:
- `BLINK_FRAMES`, 30: frames per half-period of the game-over blink (≥1).
- `OVER_FRAMES`, 180: frames spent in OVER before returning to IDLE (≥1, ≤255).

Ports:
- `clk75MHz`  in  1: the single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle start request (debounced upstream).
- `point`  in  1: one-cycle score event, +1 point.
- `Kollision`  in  1: one-cycle collision event, ends the game.
- `frame_start`  in  1: one-cycle pulse at the start of vertical blank.
- `Punkte`  out  16: displayed score, 4 BCD nibbles, [15:12] = thousands.
- `HighScore`  out  16: high score, 4 BCD nibbles.
- `state`  out  2: 0 = IDLE, 1 = RUN, 2 = OVER (3 is never produced).
- `game_active`  out  1: high in RUN.
- `show_digits`  out  1: digit-render enable; blinks in OVER.

## Operation
- Internal `score` register, 16-bit BCD. It is separate from `Punkte`, which is the display copy.
- IDLE:
  - `start` → RUN on the next edge.
  - `score` clears to 0 on that same edge.
  - `point` and `Kollision` are ignored.
- RUN:
  - `point` increments `score` in BCD: a nibble of 9 wraps to 0 and carries into the next nibble.
  - `score` saturates at 9999; a further `point` leaves it unchanged.
  - `Kollision` → OVER.
  - `start` is ignored.
- RUN to OVER transition:
  - On the transition edge, `HighScore` ← `score_next` if `score_next` > `HighScore`.
  - `score_next` is `score` including any `point` in the same cycle. BCD magnitude compare equals unsigned 16-bit compare.
  - The frame counter and blink counter clear on that same edge.
- OVER:
  - Each `frame_start` increments the frame counter and the blink counter.
  - When the blink counter reaches `BLINK_FRAMES`, it clears and `show_digits` toggles.
  - When the frame counter reaches `OVER_FRAMES`, the state returns to IDLE and `show_digits` is forced to 1.
  - `start`, `point` and `Kollision` are ignored. `score` holds.
- `show_digits` is 1 in IDLE and RUN.
- Display latch: on every `frame_start` in any state, `Punkte` ← `score`. This uses the registered value, so a `point` in the same cycle appears one frame later.
- `HighScore` is never cleared except by reset.

## Timing
- Reset values:
  - `Punkte` = 0x0000, `HighScore` = 0x0000, internal `score` = 0.
  - `state` = IDLE, `game_active` = 0, `show_digits` = 1.
  - Frame counter and blink counter = 0.
- Reset takes effect immediately at any point, including mid-RUN or mid-OVER. Release is synchronous to the next `clk75MHz` edge.
- Latencies:
  - `point` at edge t → `score` updated at t+1.
  - `Punkte` reflects `score` one cycle after the next `frame_start`.
  - `start` or `Kollision` at edge t → `state` and `game_active` change at t+1.
  - `HighScore` updates at t+1 of `Kollision`.
  - OVER ends one cycle after the `OVER_FRAMES`-th `frame_start` in OVER.
- Simultaneous events:
  - `point` + `Kollision` in RUN: the point counts and is included in the high-score compare.
  - `frame_start` + `start` in IDLE: `Punkte` latches the old `score`; the cleared score shows at the next frame.
  - `frame_start` on the RUN→OVER edge does not count toward `OVER_FRAMES`.
- `show_digits` changes only on `frame_start` edges. Blink and exit can coincide on the final frame; exit wins and `show_digits` = 1.

## Test plan
- Reset then idle: pulse `point` ×5 and `Kollision` in IDLE → `score` and `Punkte` stay 0x0000, `state` = 0.
- BCD carry: `start`, 10 `point` pulses, then `frame_start` → `Punkte` = 0x0010. Continue to 0x0099 plus 1 point, then `frame_start` → `Punkte` = 0x0100.
- Saturation: preload via 9999 points, then 3 more → `Punkte` = 0x9999 after `frame_start`, no wrap.
- High score: game 1 scores 0x0042 then `Kollision` → `HighScore` = 0x0042. Game 2 scores 0x0017 with `point` + `Kollision` in the same cycle → `HighScore` remains 0x0042. Game 3 scores 0x0042 with a simultaneous `point` → `HighScore` = 0x0043.
- OVER sequencing (`BLINK_FRAMES`=2, `OVER_FRAMES`=6): after `Kollision`, `show_digits` toggles after frames 2 and 4, giving 0 then 1. The state returns to IDLE one cycle after frame 6 with `show_digits` = 1. `start` during OVER is ignored.
- Async reset mid-RUN with score 0x0123: assert `rst_n` = 0 between edges → all outputs take reset values immediately. A new `start` after release gives `state` = 1.
